// File: rtl/cpu_fetch_pkg.sv
// rtl/cpu_fetch_pkg.sv - shared types and default widths for the fetch controller
package cpu_fetch_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_HOLD,
    S_REDIR
  } fetch_state_t;

endpackage

// File: rtl/cpu_fetch_ctrl_if.sv
// rtl/cpu_fetch_ctrl_if.sv - PC latch, instruction memory, decode and redirect signals
interface cpu_fetch_ctrl_if
  import cpu_fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic              pc_load;
  logic              pc_inc;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] ir_q;
  logic              instr_valid;
  logic              instr_ready;
  logic              jmp_valid;
  logic [ADDR_W-1:0] jmp_addr;
  logic              jmp_ready;

  modport master (
    input  pc_q, mem_ack, mem_rdata, instr_ready, jmp_valid, jmp_addr,
    output pc_d, pc_load, pc_inc, mem_req, mem_addr, ir_q, instr_valid, jmp_ready
  );

  modport slave (
    output pc_q, mem_ack, mem_rdata, instr_ready, jmp_valid, jmp_addr,
    input  pc_d, pc_load, pc_inc, mem_req, mem_addr, ir_q, instr_valid, jmp_ready
  );

endinterface

// File: rtl/cpu_sat_counter.sv
// rtl/cpu_sat_counter.sv - enabled up-counter that sticks at all-ones
module cpu_sat_counter
  import cpu_fetch_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/cpu_fetch_ctrl.sv
// rtl/cpu_fetch_ctrl.sv - instruction fetch FSM: memory request, IR capture, decode handoff, redirects
module cpu_fetch_ctrl
  import cpu_fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  cpu_fetch_ctrl_if.master bus,
  output logic [CNT_W-1:0] fetch_cnt
);

  fetch_state_t      state_q, state_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0] pc_tgt_q, pc_tgt_d;
  logic              mem_req_q, mem_req_d;
  logic              pc_inc_q, pc_inc_d;
  logic              pc_load_q, pc_load_d;
  logic              instr_valid_q, instr_valid_d;
  logic [ADDR_W-1:0] pc_next;
  logic              deliver;

  // The latch only takes a strobe at the end of the strobe cycle, so the
  // fetch address is taken from the value the latch is about to hold.
  assign pc_next = pc_load_q ? pc_tgt_q :
                   pc_inc_q  ? bus.pc_q + ADDR_W'(1) : bus.pc_q;

  assign deliver = (state_q == S_HOLD) && !bus.jmp_valid && bus.instr_ready;

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    mem_addr_d = mem_addr_q;
    pc_tgt_d   = pc_tgt_q;
    pc_inc_d   = 1'b0;
    pc_load_d  = 1'b0;
    case (state_q)
      S_IDLE: if (en) state_d = S_REQ;
      S_REQ: begin
        if (bus.mem_ack) begin
          ir_d     = bus.mem_rdata;
          pc_inc_d = 1'b1;
          state_d  = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.jmp_valid) begin
          pc_tgt_d  = bus.jmp_addr;
          pc_load_d = 1'b1;
          state_d   = S_REDIR;
        end else if (bus.instr_ready) begin
          state_d = en ? S_REQ : S_IDLE;
        end
      end
      S_REDIR: state_d = en ? S_REQ : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    mem_req_d     = (state_d == S_REQ);
    instr_valid_d = (state_d == S_HOLD);
    if ((state_d == S_REQ) && (state_q != S_REQ)) mem_addr_d = pc_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      ir_q          <= '0;
      mem_addr_q    <= '0;
      pc_tgt_q      <= '0;
      mem_req_q     <= 1'b0;
      pc_inc_q      <= 1'b0;
      pc_load_q     <= 1'b0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ir_q          <= ir_d;
      mem_addr_q    <= mem_addr_d;
      pc_tgt_q      <= pc_tgt_d;
      mem_req_q     <= mem_req_d;
      pc_inc_q      <= pc_inc_d;
      pc_load_q     <= pc_load_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  cpu_sat_counter #(.CNT_W(CNT_W)) u_fetch_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (deliver),
    .cnt   (fetch_cnt)
  );

  assign bus.pc_d        = pc_tgt_q;
  assign bus.pc_load     = pc_load_q;
  assign bus.pc_inc      = pc_inc_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.ir_q        = ir_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.jmp_ready   = (state_q == S_HOLD) && bus.jmp_valid;

  a_no_inc_with_load: assert property (@(posedge clk) disable iff (!rst_n)
    !(pc_inc_q && pc_load_q));

endmodule

// File: tb/tb_cpu_fetch_ctrl.sv
// tb/tb_cpu_fetch_ctrl.sv - directed bench for cpu_fetch_ctrl with PC latch and memory models
module tb_cpu_fetch_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] fetch_cnt;

  int total = 0;
  int bad   = 0;

  logic       pc_wr;
  logic [7:0] pc_wval;
  logic [7:0] pc_r;
  logic       auto_en;
  logic [3:0] ack_dly;
  logic [3:0] wait_cnt = '0;
  logic       auto_ack = 1'b0;
  logic [7:0] auto_data = '0;
  logic       man_ack;
  logic [7:0] man_data;

  cpu_fetch_ctrl_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  cpu_fetch_ctrl #(.ADDR_W(8), .DATA_W(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .bus       (bus),
    .fetch_cnt (fetch_cnt)
  );

  always #5 clk = ~clk;

  // PC latch: 2'b11 on load/inc is a no-op
  always @(posedge clk) begin
    if (pc_wr)                           pc_r <= pc_wval;
    else if (bus.pc_load && !bus.pc_inc) pc_r <= bus.pc_d;
    else if (bus.pc_inc && !bus.pc_load) pc_r <= pc_r + 8'd1;
  end
  assign bus.pc_q = pc_r;

  // Memory: word = address ^ 0xB5, ack after ack_dly waiting cycles
  always @(posedge clk) begin
    if (auto_en && bus.mem_req && !auto_ack) begin
      if (wait_cnt == ack_dly) begin
        auto_ack  <= 1'b1;
        auto_data <= bus.mem_addr ^ 8'hB5;
        wait_cnt  <= '0;
      end else begin
        auto_ack <= 1'b0;
        wait_cnt <= wait_cnt + 4'd1;
      end
    end else begin
      auto_ack <= 1'b0;
      wait_cnt <= '0;
    end
  end
  assign bus.mem_ack   = auto_en ? auto_ack  : man_ack;
  assign bus.mem_rdata = auto_en ? auto_data : man_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; bus.instr_ready = 1'b0;
    bus.jmp_valid = 1'b1; bus.jmp_addr = 8'h00;
    auto_en = 1'b1; ack_dly = 4'd0; man_ack = 1'b0; man_data = 8'h00;
    pc_wr = 1'b1; pc_wval = 8'h10;

    // reset state
    cyc(2); #1;
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_pc_load", bus.pc_load, 0);
    chk("rst_pc_inc", bus.pc_inc, 0);
    chk("rst_instr_valid", bus.instr_valid, 0);
    chk("rst_jmp_ready", bus.jmp_ready, 0);
    chk("rst_ir_q", bus.ir_q, 0);
    chk("rst_pc_d", bus.pc_d, 0);
    chk("rst_fetch_cnt", fetch_cnt, 0);

    // basic fetch from 0x10, 1-cycle ack, decode ready
    bus.jmp_valid = 1'b0; rst_n = 1'b1; pc_wr = 1'b0; en = 1'b1; bus.instr_ready = 1'b1;
    cyc(1);
    chk("f1_c0_req", bus.mem_req, 1);
    chk("f1_c0_addr", bus.mem_addr, 8'h10);
    chk("f1_c0_valid", bus.instr_valid, 0);
    cyc(1);
    chk("f1_c1_req", bus.mem_req, 1);
    chk("f1_c1_valid", bus.instr_valid, 0);
    chk("f1_c1_inc", bus.pc_inc, 0);
    cyc(1);
    chk("f1_c2_valid", bus.instr_valid, 1);
    chk("f1_c2_ir", bus.ir_q, 8'hA5);
    chk("f1_c2_inc", bus.pc_inc, 1);
    chk("f1_c2_cnt", fetch_cnt, 0);
    cyc(1);
    chk("f1_c3_inc_single", bus.pc_inc, 0);
    chk("f1_c3_cnt", fetch_cnt, 1);
    chk("f2_addr", bus.mem_addr, 8'h11);

    // decode stall for 5 cycles
    bus.instr_ready = 1'b0;
    cyc(2);
    chk("stall_valid", bus.instr_valid, 1);
    chk("stall_ir", bus.ir_q, 8'hA4);
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("stall_hold_valid", bus.instr_valid, 1);
      chk("stall_hold_ir", bus.ir_q, 8'hA4);
      chk("stall_no_req", bus.mem_req, 0);
      chk("stall_cnt", fetch_cnt, 1);
    end
    bus.instr_ready = 1'b1; en = 1'b0;
    cyc(1);
    chk("stall_done_cnt", fetch_cnt, 2);
    chk("stall_done_valid", bus.instr_valid, 0);
    chk("stall_done_req", bus.mem_req, 0);

    // jump in HOLD together with instr_ready: jump wins
    bus.instr_ready = 1'b0; en = 1'b1;
    cyc(1);
    chk("j1_addr", bus.mem_addr, 8'h12);
    cyc(2);
    bus.jmp_valid = 1'b1; bus.jmp_addr = 8'h40; bus.instr_ready = 1'b1;
    #1;
    chk("j1_valid", bus.instr_valid, 1);
    chk("j1_jmp_ready", bus.jmp_ready, 1);
    cyc(1);
    bus.jmp_valid = 1'b0; bus.instr_ready = 1'b0;
    #1;
    chk("j1_pc_load", bus.pc_load, 1);
    chk("j1_pc_d", bus.pc_d, 8'h40);
    chk("j1_pc_inc", bus.pc_inc, 0);
    chk("j1_squash_valid", bus.instr_valid, 0);
    chk("j1_squash_cnt", fetch_cnt, 2);
    chk("j1_bubble_req", bus.mem_req, 0);
    cyc(1);
    chk("j1_new_req", bus.mem_req, 1);
    chk("j1_new_addr", bus.mem_addr, 8'h40);
    chk("j1_load_single", bus.pc_load, 0);
    en = 1'b0;
    cyc(2);
    chk("j1_new_ir", bus.ir_q, 8'hF5);
    bus.instr_ready = 1'b1;
    cyc(1);
    bus.instr_ready = 1'b0;
    chk("j1_cnt_after", fetch_cnt, 3);

    // redirect requested during a slow fetch is held off
    en = 1'b1; bus.jmp_valid = 1'b1; bus.jmp_addr = 8'h80; ack_dly = 4'd3;
    cyc(1);
    chk("j2_addr", bus.mem_addr, 8'h41);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("j2_req_held", bus.mem_req, 1);
      chk("j2_jmp_blocked", bus.jmp_ready, 0);
      chk("j2_no_load", bus.pc_load, 0);
      cyc(1);
    end
    #1;
    chk("j2_hold_valid", bus.instr_valid, 1);
    chk("j2_hold_jmp_ready", bus.jmp_ready, 1);
    chk("j2_hold_inc", bus.pc_inc, 1);
    chk("j2_hold_no_load", bus.pc_load, 0);
    cyc(1);
    bus.jmp_valid = 1'b0; en = 1'b0;
    #1;
    chk("j2_load", bus.pc_load, 1);
    chk("j2_no_inc", bus.pc_inc, 0);
    chk("j2_pc_d", bus.pc_d, 8'h80);
    chk("j2_cnt", fetch_cnt, 3);
    cyc(1);
    chk("j2_idle_req", bus.mem_req, 0);
    chk("j2_idle_valid", bus.instr_valid, 0);

    // reset mid-fetch, then a late ack
    auto_en = 1'b0; ack_dly = 4'd0; en = 1'b1;
    cyc(1);
    chk("r_req", bus.mem_req, 1);
    chk("r_addr", bus.mem_addr, 8'h80);
    #2 rst_n = 1'b0;
    #1;
    chk("r_async_req", bus.mem_req, 0);
    chk("r_async_ir", bus.ir_q, 0);
    chk("r_async_pc_d", bus.pc_d, 0);
    chk("r_async_cnt", fetch_cnt, 0);
    man_ack = 1'b1; man_data = 8'h77;
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    man_ack = 1'b0;
    chk("r_late_ack_ir", bus.ir_q, 0);
    chk("r_late_ack_valid", bus.instr_valid, 0);
    chk("r_restart_req", bus.mem_req, 1);
    chk("r_restart_addr", bus.mem_addr, 8'h80);
    auto_en = 1'b1;
    cyc(2);
    chk("r_restart_ir", bus.ir_q, 8'h35);
    chk("r_restart_valid", bus.instr_valid, 1);
    bus.instr_ready = 1'b1; en = 1'b0;
    cyc(1);
    chk("r_restart_cnt", fetch_cnt, 1);

    // back-to-back fetches across PC wrap; counter saturates at 15
    pc_wr = 1'b1; pc_wval = 8'hF0;
    cyc(1);
    pc_wr = 1'b0; en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      chk("s_req", bus.mem_req, 1);
      chk("s_addr", bus.mem_addr, (32'hF0 + i) & 32'hFF);
      chk("s_cnt", fetch_cnt, (i + 1 > 15) ? 15 : i + 1);
      cyc(2);
    end
    cyc(1);
    en = 1'b0;
    chk("s_sat_cnt", fetch_cnt, 15);
    chk("s_after_wrap_addr", bus.mem_addr, 8'h04);
    cyc(3);
    chk("s_sat_hold_cnt", fetch_cnt, 15);
    chk("s_end_req", bus.mem_req, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
